ifetch_ctrl: RTL
================

Name: ifetch_ctrl

Overview:
- Consumer side of the PC register interface. Reads `pc` and drives `next_pc`, which the PC register loads every cycle.
- Issues instruction-memory requests at `pc` and buffers returned instructions with their PC in a 2-entry queue for decode.
- Handles redirects from EX by flushing the queue and discarding any in-flight response.
- Sits between the PC register, instruction memory and the decode stage of the RV32I core.

Parameters:
- RESET_PC, 32'h0000_0000, value driven on `next_pc` while reset is asserted.
- BUF_DEPTH, 2, instruction queue depth. Fixed at 2; other values unsupported.

Ports:
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  asynchronous active-low reset
- pc  in  32  current PC from PC register
- next_pc  out  32  value the PC register loads next edge
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  request address = {pc[31:2],2'b00}
- imem_rsp_valid  in  1  response valid, in order, ≥1 cycle after accepted request
- imem_rsp_data  in  32  fetched instruction
- redirect_valid  in  1  branch/jump redirect from EX
- redirect_pc  in  32  redirect target
- inst_valid  out  1  queue head valid to decode
- inst_ready  in  1  decode accepts head
- inst_data  out  32  head instruction
- inst_pc  out  32  PC of head instruction

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, queue count=0, kill flag cleared.
  - imem_req_valid=0, inst_valid=0, next_pc=RESET_PC, inst_data=0, inst_pc=0.
- Single outstanding request max; req_pc register holds the address of the outstanding request.
- States: IDLE, WAIT, WAIT_KILL.
- IDLE:
  - imem_req_valid = (count<2) & !redirect_valid.
  - redirect_valid → next_pc=redirect_pc, stay IDLE.
  - req handshake (valid&ready) → next_pc=pc+4, req_pc←pc, go WAIT.
  - Otherwise next_pc=pc (hold).
- WAIT:
  - imem_req_valid=0.
  - rsp_valid & !redirect_valid → push {req_pc, rsp_data}, go IDLE.
  - rsp_valid & redirect_valid → drop response, go IDLE.
  - redirect_valid & !rsp_valid → go WAIT_KILL.
  - next_pc=redirect_pc on redirect, else pc.
- WAIT_KILL:
  - imem_req_valid=0.
  - rsp_valid → drop, go IDLE.
  - Further redirects update next_pc only.
- Redirect in any state flushes the queue (count←0) that edge. Flush overrides a same-cycle pop and push.
- Queue:
  - inst_valid = count!=0; head drives inst_data/inst_pc.
  - Pop on inst_valid&inst_ready.
  - Simultaneous push and pop with count=1 → count stays 1, order preserved.
  - The credit rule (issue only when count<2, one outstanding) guarantees no push when full. Push into a full queue is an assertion failure.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC → 32'h0000_0000. Unaligned pc[1:0] is masked on imem_req_addr; next_pc uses the full pc+4.
- Throughput: one instruction per 2 cycles with single-cycle memory (no request issued in the response cycle). This is accepted for this revision.
- imem_req_valid, once asserted, may drop only on redirect.
- Reset asserted mid-request: state cleared immediately. A later stale response while IDLE is ignored (rsp_valid in IDLE is don't-care).

Decomposition:
- Package rv32i_fetch_pkg:
  - fetch_state_t enum {IDLE, WAIT, WAIT_KILL}
  - PC_STEP=32'd4
  - XLEN=32
  - fetch_entry_t struct {pc[31:0], inst[31:0]}
- Sub-module fetch_buf: 2-entry FIFO of fetch_entry_t with push, pop, flush, count. Asynchronous active-low reset.

Test Plan:
- Reset release, pc=0, ready=1, 1-cycle memory returning 0x00000013 → req addr 0, next_pc=4 on handshake, inst_valid=1 with inst_pc=0, inst_data=0x00000013. Steady state has 1 instruction per 2 cycles.
- inst_ready=0 for 10 cycles → after 2 fetches (pc 0,4) imem_req_valid stays 0 and next_pc holds 8. Releasing inst_ready drains 0 then 4 in order, after which fetching resumes at 8.
- Redirect to 0x100 while in WAIT, response arrives 3 cycles later → response dropped, queue empty, next request addr 0x100.
- redirect_valid and rsp_valid same cycle → response dropped, next_pc=redirect_pc, state IDLE, no push.
- pc=32'hFFFF_FFFC fetch → next_pc=32'h0000_0000, inst_pc=32'hFFFF_FFFC.
- reset low during WAIT with memory stalled → imem_req_valid=0, inst_valid=0, next_pc=RESET_PC immediately (asynchronous). After release, fetch restarts from pc cleanly.

Source files
------------

// File: rtl/rv32i_fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch slice.
package rv32i_fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        WAIT_KILL
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Small FIFO of fetched {pc, instruction} entries feeding decode.
// A flush empties it outright and wins over any same-cycle push or pop.
module fetch_buf
    import rv32i_fetch_pkg::*;
#(
    parameter int BUF_DEPTH = 2,
    localparam int CNT_W = $clog2(BUF_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(BUF_DEPTH);

    fetch_entry_t     entries [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;

    assign do_pop = pop && (count != '0);
    assign head   = entries[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                entries[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= push_entry;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // The fetch credit rule must never let a response land in a full buffer.
    push_into_full: assert property (@(posedge clk) disable iff (!reset)
        !(push && !flush && (count == FULL_COUNT)));

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch controller: steers the PC register, issues one outstanding
// instruction-memory request at a time and queues results for decode.
module ifetch_ctrl
    import rv32i_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] next_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(BUF_DEPTH);

    fetch_state_t     state;
    logic [XLEN-1:0]  req_pc;
    logic [CNT_W-1:0] buf_count;
    logic             req_fire;
    logic             buf_push;
    logic             buf_pop;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    // Only issue when a free slot is guaranteed for the response.
    assign imem_req_valid = reset && (state == IDLE) && (buf_count < FULL_COUNT)
                            && !redirect_valid;
    assign imem_req_addr  = {pc[XLEN-1:2], 2'b00};
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign buf_push   = (state == WAIT) && imem_rsp_valid && !redirect_valid;
    assign push_entry = '{pc: req_pc, inst: imem_rsp_data};
    assign inst_valid = (buf_count != '0);
    assign buf_pop    = inst_valid && inst_ready;
    assign inst_data  = head.inst;
    assign inst_pc    = head.pc;

    always_comb begin
        if (!reset) begin
            next_pc = RESET_PC;
        end else if (redirect_valid) begin
            next_pc = redirect_pc;
        end else if (req_fire) begin
            next_pc = pc + PC_STEP;
        end else begin
            next_pc = pc;
        end
    end

    // WAIT_KILL remembers that the outstanding response belongs to a dead path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            req_pc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        req_pc <= pc;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        state <= IDLE;
                    end else if (redirect_valid) begin
                        state <= WAIT_KILL;
                    end
                end
                WAIT_KILL: begin
                    if (imem_rsp_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fetch_buf #(
        .BUF_DEPTH(BUF_DEPTH)
    ) u_fetch_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (buf_push),
        .push_entry(push_entry),
        .pop       (buf_pop),
        .flush     (redirect_valid),
        .count     (buf_count),
        .head      (head)
    );

endmodule
